// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: LANES inverse S-box lookups per cycle over a 128-bit state.
// Optional macro INV_SBOX_SELFCHECK_EN adds a forward S-box round-trip check driving chk_err.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic         chk_err,
  output logic [1:0]   fsm_state
);

  localparam int C  = 16 / LANES;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int LW = 8 * LANES;

  // Entry for byte b sits at bits [2047-8b -: 8] (row-major, 0x00 leftmost).
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b111};
    return INV_SBOX[idx -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [127:0]  work;
  logic [6:0]    hi;
  logic [LW-1:0] lane_in;
  logic [LW-1:0] lane_out;

  // MSB of the lane group handled this pass; byte 0 is processed first.
  assign hi        = 7'(127 - LW * int'(cnt));
  assign lane_in   = work[hi -: LW];
  assign out_state = work;
  assign fsm_state = state;

  always_comb begin
    lane_out = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_out[8*l +: 8] = inv_sbox(lane_in[8*l +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_state;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          work[hi -: LW] <= lane_out;
          if (cnt == CW'(C - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INV_SBOX_SELFCHECK_EN
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b111};
    return FWD_SBOX[idx -: 8];
  endfunction

  logic chk_mismatch;

  always_comb begin
    chk_mismatch = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (fwd_sbox(lane_out[8*l +: 8]) != lane_in[8*l +: 8]) chk_mismatch = 1'b1;
    end
  end

  // Sticky until reset; only meaningful while a pass is actually being written.
  always_ff @(posedge clk) begin
    if (rst) chk_err <= 1'b0;
    else if (state == BUSY && chk_mismatch) chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule
